// File: rtl/fib_ctrl_if.sv
// Bundle of request, engine and response signals for fib_ctrl.
//   in_*   : request stream (valid/ready, n)
//   fib_*  : engine go/n pulse protocol and done/result/overflow return
//   out_*  : response stream (valid/ready, n, result, overflow, latency)
// slave  : controller side (fib_ctrl)
// master : environment side (request source, engine, response sink)
interface fib_ctrl_if #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter int CYCLE_WIDTH  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [INPUT_WIDTH-1:0]  in_n;
    logic                    fib_go;
    logic [INPUT_WIDTH-1:0]  fib_n;
    logic                    fib_done;
    logic [OUTPUT_WIDTH-1:0] fib_result;
    logic                    fib_overflow;
    logic                    out_valid;
    logic                    out_ready;
    logic [INPUT_WIDTH-1:0]  out_n;
    logic [OUTPUT_WIDTH-1:0] out_result;
    logic                    out_overflow;
    logic [CYCLE_WIDTH-1:0]  out_cycles;

    modport slave (
        input  in_valid, in_n, fib_done, fib_result, fib_overflow, out_ready,
        output in_ready, fib_go, fib_n, out_valid, out_n, out_result, out_overflow,
               out_cycles
    );

    modport master (
        output in_valid, in_n, fib_done, fib_result, fib_overflow, out_ready,
        input  in_ready, fib_go, fib_n, out_valid, out_n, out_result, out_overflow,
               out_cycles
    );
endinterface

// File: rtl/fib_ctrl.sv
// Upstream request controller for the fib engine. Takes one n at a time from the
// request stream, pulses go to the engine, waits for done, then holds the captured
// result/overflow and measured latency on the response stream until accepted.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : fib_ctrl_if.slave (request, engine and response signals)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request (in_ready=1)
// START | one-cycle fib_go pulse to the engine, counter set to 1
// WAIT  | counting latency, waiting for fib_done
// OUT   | response presented (out_valid=1) until out_ready
module fib_ctrl #(
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter int CYCLE_WIDTH  = 16
) (
    input logic     clk,
    input logic     rst,
    fib_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [CYCLE_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CYCLE_WIDTH-1:0] CNT_ONE = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nxt;
    logic                    in_ready;
    logic                    accept;
    logic [INPUT_WIDTH-1:0]  fib_n_q;
    logic [CYCLE_WIDTH-1:0]  cnt;
    logic [INPUT_WIDTH-1:0]  out_n_q;
    logic [OUTPUT_WIDTH-1:0] out_result_q;
    logic                    out_overflow_q;
    logic [CYCLE_WIDTH-1:0]  out_cycles_q;

    // Gated with rst so the request side sees not-ready during reset even though
    // the state register already sits in IDLE.
    assign in_ready = (state == IDLE) && rst;
    assign accept   = bus.in_valid && in_ready;

    // go and valid are state decodes, so they drop the instant reset asserts.
    assign bus.in_ready     = in_ready;
    assign bus.fib_go       = (state == START);
    assign bus.fib_n        = fib_n_q;
    assign bus.out_valid    = (state == OUT);
    assign bus.out_n        = out_n_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_overflow = out_overflow_q;
    assign bus.out_cycles   = out_cycles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (bus.fib_done) state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fib_n_q        <= '0;
            cnt            <= '0;
            out_n_q        <= '0;
            out_result_q   <= '0;
            out_overflow_q <= 1'b0;
            out_cycles_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fib_n_q <= bus.in_n;
                        cnt     <= '0;
                    end
                end
                START: begin
                    cnt <= CNT_ONE;
                end
                WAIT: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    // The counter value in this cycle is the latency seen so far,
                    // including the cycle in which done is observed.
                    if (bus.fib_done) begin
                        out_n_q        <= fib_n_q;
                        out_result_q   <= bus.fib_result;
                        out_overflow_q <= bus.fib_overflow;
                        out_cycles_q   <= cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_go_single: assert property (@(posedge clk) disable iff (!rst)
        bus.fib_go |=> !bus.fib_go);

    a_out_stable: assert property (@(posedge clk) disable iff (!rst)
        (bus.out_valid && !bus.out_ready) |=>
            ($stable(bus.out_n) && $stable(bus.out_result) &&
             $stable(bus.out_overflow) && $stable(bus.out_cycles) && bus.out_valid));

    a_fib_n_stable: assert property (@(posedge clk) disable iff (!rst)
        (state != IDLE) |=> $stable(bus.fib_n));

endmodule
